// File: rtl/ahb_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master_pkg
//  Description : Shared AHB-lite transfer-type constants and the command
//                master FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage : ahb_master_pkg
`default_nettype wire

// File: rtl/ahb_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_wait_timer
//  Description : Saturating counter of consecutive data-phase wait cycles.
//                expired is asserted in the wait cycle that brings the count
//                up to TIMEOUT, so the owner can leave the data phase on that
//                same clock edge.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset
//                clear   - restart the count (entry into the data phase)
//                enable  - current cycle is a wait cycle
//                expired - this wait cycle is the TIMEOUT-th one
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] C_LIMIT = 8'(TIMEOUT);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= 8'd0;
    end else if (enable && (r_count != C_LIMIT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Count already holds TIMEOUT-1 earlier waits; this one is the last allowed.
  assign expired = enable && (r_count >= (C_LIMIT - 8'd1));

endmodule : ahb_wait_timer
`default_nettype wire

// File: rtl/ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_cmd_master
//  Description : Converts single valid/ready commands into non-pipelined
//                AHB-lite transfers (IDLE -> ADDR -> DATA -> RESP) and returns
//                the result on a valid/ready response channel. A data phase
//                that waits TIMEOUT cycles is aborted with an error response.
//  Ports       : clk, reset                     - clock, sync active-high reset
//                cmd_valid/cmd_ready            - command handshake
//                cmd_write/cmd_addr/cmd_wdata   - command payload
//                rsp_valid/rsp_ready            - response handshake
//                rsp_rdata/rsp_err              - read data and error flag
//                m_hsel/m_haddr/m_hwrite/
//                m_htrans/m_hwdata/m_hready     - AHB-lite request to slave
//                s_hrdata/s_hreadyout/s_hresp   - slave response
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_cmd_master
  import ahb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              m_hsel,
  output logic [ADDR_W-1:0] m_haddr,
  output logic              m_hwrite,
  output logic [1:0]        m_htrans,
  output logic [DATA_W-1:0] m_hwdata,
  output logic              m_hready,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hreadyout,
  input  logic              s_hresp
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_expired;

  // Counter restarts while in ADDR so it is zero on the first DATA cycle.
  ahb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (reset),
    .clear   (r_state == ADDR),
    .enable  ((r_state == DATA) && !s_hreadyout),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr  <= cmd_addr;
            r_write <= cmd_write;
            r_wdata <= cmd_wdata;
            r_state <= ADDR;
          end
        end
        ADDR: r_state <= DATA;
        DATA: begin
          if (s_hreadyout) begin
            r_rdata <= r_write ? '0 : s_hrdata;
            r_err   <= s_hresp;
            r_state <= RESP;
          end else if (w_expired) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset gates cmd_ready so no command is taken while reset is held.
  assign cmd_ready = (r_state == IDLE) && !reset;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign m_hsel   = (r_state == ADDR);
  assign m_htrans = (r_state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign m_haddr  = (r_state == ADDR) ? r_addr : '0;
  assign m_hwrite = (r_state == ADDR) && r_write;
  assign m_hwdata = ((r_state == DATA) && r_write) ? r_wdata : '0;
  // Only the data phase forwards the slave's stall.
  assign m_hready = (r_state == DATA) ? s_hreadyout : 1'b1;

endmodule : ahb_cmd_master
`default_nettype wire

// File: tb/tb_ahb_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_cmd_master
//  Description : Self-checking bench for ahb_cmd_master. Expected responses
//                and phase lengths come from a transaction-level model of the
//                master's rules (wait count, timeout, read/write data).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_cmd_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              m_hsel, m_hwrite, m_hready;
  logic [ADDR_W-1:0] m_haddr;
  logic [1:0]        m_htrans;
  logic [DATA_W-1:0] m_hwdata;
  logic [DATA_W-1:0] s_hrdata;
  logic              s_hreadyout, s_hresp;

  int vectors     = 0;
  int miscompares = 0;

  ahb_cmd_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .m_hsel      (m_hsel),
    .m_haddr     (m_haddr),
    .m_hwrite    (m_hwrite),
    .m_htrans    (m_htrans),
    .m_hwdata    (m_hwdata),
    .m_hready    (m_hready),
    .s_hrdata    (s_hrdata),
    .s_hreadyout (s_hreadyout),
    .s_hresp     (s_hresp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_hsel"},   m_hsel,   1'b0);
    chk({tag, "_htrans"}, m_htrans, 2'b00);
    chk({tag, "_haddr"},  m_haddr,  '0);
    chk({tag, "_hwrite"}, m_hwrite, 1'b0);
  endtask

  // One full transfer. waits = slave wait cycles before HREADYOUT rises.
  task automatic do_txn(input logic write, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic resp, input int waits, input int rsp_delay);
    bit          tmo       = (waits >= TIMEOUT);
    int          dcyc      = tmo ? TIMEOUT : waits + 1;
    logic [31:0] exp_rdata = (tmo || write) ? 32'h0 : rdata;
    logic        exp_err   = tmo ? 1'b1 : resp;

    chk("idle_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_wdata = wdata;
    step();
    // Scramble payload: the master must use its own registered copy.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    s_hreadyout = 1'($urandom);
    #1;
    chk("addr_hsel",     m_hsel,    1'b1);
    chk("addr_htrans",   m_htrans,  2'b10);
    chk("addr_haddr",    m_haddr,   addr);
    chk("addr_hwrite",   m_hwrite,  write);
    chk("addr_hready",   m_hready,  1'b1);
    chk("addr_cmd_rdy",  cmd_ready, 1'b0);
    chk("addr_rsp_vld",  rsp_valid, 1'b0);
    step();
    for (int i = 0; i < dcyc; i++) begin
      s_hreadyout = (i == waits);
      s_hresp     = (i == waits) ? resp : 1'b0;
      s_hrdata    = (i == waits) ? rdata : $urandom;
      #1;
      chk_idle_bus("data");
      chk("data_hwdata",  m_hwdata,  write ? wdata : 32'h0);
      chk("data_hready",  m_hready,  (i == waits));
      chk("data_rsp_vld", rsp_valid, 1'b0);
      chk("data_cmd_rdy", cmd_ready, 1'b0);
      step();
    end
    s_hreadyout = 1'b1; s_hresp = 1'b0;
    cmd_valid = 1'b1;   // must not be taken while a response is pending
    for (int j = 0; j <= rsp_delay; j++) begin
      rsp_ready = (j == rsp_delay);
      s_hrdata  = $urandom;
      #1;
      chk("resp_valid",   rsp_valid, 1'b1);
      chk("resp_rdata",   rsp_rdata, exp_rdata);
      chk("resp_err",     rsp_err,   exp_err);
      chk("resp_cmd_rdy", cmd_ready, 1'b0);
      chk("resp_hwdata",  m_hwdata,  32'h0);
      chk("resp_hready",  m_hready,  1'b1);
      chk_idle_bus("resp");
      step();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_cmd_ready", cmd_ready, 1'b1);
    chk("post_hsel",      m_hsel,    1'b0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; s_hrdata = '0; s_hreadyout = 1'b1; s_hresp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata",     rsp_rdata, 32'h0);
    chk("rst_err",       rsp_err,   1'b0);
    chk("rst_hwdata",    m_hwdata,  32'h0);
    chk("rst_hready",    m_hready,  1'b1);
    chk_idle_bus("rst");
    reset = 1'b0;
    #1;
    chk("rst_rel_cmd_ready", cmd_ready, 1'b1);

    // Directed: zero-wait read, 2-wait write, error, timeout, backpressure.
    do_txn(1'b0, 32'h1, 32'h0,        32'hCAFE0001, 1'b0, 0, 0);
    do_txn(1'b1, 32'h0, 32'h12345678, 32'hDEAD0000, 1'b0, 2, 0);
    do_txn(1'b0, 32'h40, 32'h0,       32'h0BAD0BAD, 1'b1, 1, 0);
    do_txn(1'b0, 32'h80, 32'h0,       32'h55555555, 1'b0, 100, 0);
    do_txn(1'b1, 32'hC4, 32'hA5A5A5A5, 32'h0,       1'b0, 0, 5);

    // Reset in the middle of a data phase.
    chk("mid_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'hFEEDBEEF;
    step();
    cmd_valid = 1'b0;
    s_hreadyout = 1'b0;
    step();
    #1;
    chk("mid_in_data_hwdata", m_hwdata, 32'hFEEDBEEF);
    reset = 1'b1;
    step();
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_hwdata",    m_hwdata,  32'h0);
    chk("mid_rst_hready",    m_hready,  1'b1);
    chk("mid_rst_err",       rsp_err,   1'b0);
    chk_idle_bus("mid_rst");
    reset = 1'b0; s_hreadyout = 1'b1;
    #1;
    chk("mid_rel_cmd_ready", cmd_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_after_rsp_valid", rsp_valid, 1'b0);
      chk("mid_after_cmd_ready", cmd_ready, 1'b1);
    end

    // Randomized transfers checked against the transaction model.
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), $urandom, $urandom, $urandom,
             ($urandom_range(0, 3) == 0), $urandom_range(0, 6), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ahb_cmd_master
`default_nettype wire

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AHB address width.
REQ-002 SHALL have parameter DATA_W, default 32, AHB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum data-phase wait cycles before abort (range 1..255).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cmd_valid in 1 and cmd_ready out 1: command handshake.
REQ-007 SHALL have ports cmd_write in 1, cmd_addr in ADDR_W and cmd_wdata in DATA_W: command payload, valid with cmd_valid.
REQ-008 SHALL have ports rsp_valid out 1 and rsp_ready in 1: response handshake.
REQ-009 SHALL have ports rsp_rdata out DATA_W and rsp_err out 1: read data (0 on writes) and error flag.
REQ-010 SHALL have ports m_hsel out 1, m_haddr out ADDR_W, m_hwrite out 1, m_htrans out 2 and m_hwdata out DATA_W: AHB-lite request to the slave.
REQ-011 SHALL have port m_hready out 1: HREADY into the slave.
REQ-012 SHALL have ports s_hrdata in DATA_W, s_hreadyout in 1 and s_hresp in 1: slave response.

Function
REQ-013 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE, with one transfer outstanding at a time and no pipelining.
REQ-014 SHALL assert cmd_ready only in IDLE, and SHALL register the payload and go to ADDR on cmd_valid&cmd_ready.
REQ-015 In ADDR (exactly 1 cycle), SHALL drive m_hsel=1, m_htrans=NONSEQ(2'b10), m_haddr=cmd_addr unchanged and m_hwrite=cmd_write, then go to DATA.
REQ-016 In DATA, SHALL drive m_hsel=0, m_htrans=IDLE(2'b00) and m_hwdata=registered wdata for writes, otherwise 0.
REQ-017 SHALL drive m_hready=1 in IDLE, ADDR and RESP, and m_hready=s_hreadyout in DATA.
REQ-018 In DATA with s_hreadyout=1, SHALL capture rsp_rdata=s_hrdata on reads (0 on writes) and rsp_err=s_hresp, then go to RESP.
REQ-019 In DATA, SHALL count consecutive s_hreadyout=0 cycles; when the count reaches TIMEOUT, SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-020 SHALL clear the wait counter on entry to DATA, and SHALL saturate it with no wrap-around.
REQ-021 In RESP, SHALL hold rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-022 Best-case latency SHALL be: handshake at edge N -> ADDR in cycle N+1 -> DATA in N+2 -> rsp_valid in N+3.
REQ-023 A new command SHALL NOT be accepted in the cycle rsp_ready completes; earliest acceptance is the next IDLE cycle.
REQ-024 While rsp_ready=0, SHALL keep cmd_ready=0 (backpressure) with all AHB outputs at idle values.

Reset
REQ-025 On reset=1 at a clock edge, from any state including mid-transfer, SHALL go to IDLE and clear registered payload, counter, rsp_rdata and rsp_err.
REQ-026 Outputs during and after reset SHALL be: cmd_ready=0 while reset=1 and 1 after; rsp_valid=0; m_hsel=0; m_htrans=2'b00; m_haddr, m_hwrite and m_hwdata=0; m_hready=1.

Structure
REQ-027 Package ahb_master_pkg SHALL hold HTRANS_IDLE/HTRANS_NONSEQ constants and the FSM state typedef (IDLE, ADDR, DATA, RESP).
REQ-028 The wait counter SHALL be a sub-module ahb_wait_timer (clear, enable, TIMEOUT parameter, expired output).
REQ-029 All outputs SHALL be registered or derived from state only, except m_hready in DATA.

Verification
REQ-030 Read with zero wait: cmd addr=0x1, write=0; slave hrdata=0xCAFE0001, hreadyout=1 -> m_hsel=1 one cycle, rsp_valid at N+3, rdata=0xCAFE0001, err=0.
REQ-031 Write with 2 wait states: addr=0x0, wdata=0x12345678, hreadyout low 2 cycles -> m_hwdata=0x12345678 held 3 cycles, rsp_valid at N+5, rdata=0, err=0.
REQ-032 Error: s_hresp=1 with hreadyout=1 in DATA -> rsp_err=1.
REQ-033 Timeout: hreadyout held 0, TIMEOUT=4 -> rsp_valid after 4 DATA cycles, err=1, rdata=0.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles -> rsp held stable and cmd_ready=0 throughout; cmd_ready=1 the cycle after rsp_ready.
REQ-035 Reset in DATA: reset=1 one cycle -> next cycle IDLE, all outputs at reset values, no rsp_valid.
